// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and constants for the shift-and-add multiplier:
//               controller state encoding, default operand width and the
//               iteration-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Controller states; the encoding is fixed so that flop values stay
    // stable across tool versions.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Default operand width in bits.
    localparam int MUL_WIDTH = 4;

    // Width of the iteration counter, which counts 0 .. width-1.
    // A counter of at least one bit is always kept.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rca_n.sv
`default_nettype none
// ============================================================================
// Module      : rca_n
// Description : Combinational WIDTH-bit ripple-carry adder.
// Ports       : a, b  - addends (WIDTH bits)
//               cin   - carry-in
//               s     - sum (WIDTH bits)
//               cout  - carry-out of the most significant bit
// Revision    : 1.0 - initial release
// ============================================================================
module rca_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    // Carry chain: w_carry[i] is the carry into bit i.
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign s[i]         = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential unsigned WIDTH x WIDTH multiplier, one
//               shift-and-add iteration per clock, valid/ready on both sides.
// Ports       : clk, rst             - clock, asynchronous active-high reset
//               in_valid / in_ready  - operand handshake (a, b)
//               a, b                 - multiplicand / multiplier, unsigned
//               out_valid / out_ready- result handshake
//               product              - registered 2*WIDTH-bit result
// Config      : MUL_ZERO_SKIP_EN - when defined, a zero operand bypasses
//               the iteration loop and the result is ready one edge after
//               the accept.
// Revision    : 1.0 - initial release
// ============================================================================
import mul_pkg::*;

module shift_add_multiplier #(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int c_CNT_W = cnt_width(WIDTH);

    localparam logic [1:0] c_IDLE = IDLE;
    localparam logic [1:0] c_BUSY = BUSY;
    localparam logic [1:0] c_DONE = DONE;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic               w_accept;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]   w_q_next;

    // Handshake outputs decode straight from the state flops.
    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign product   = r_product;

    assign w_accept  = in_valid && (r_state == c_IDLE);

    // Add the multiplicand only when the current multiplier LSB is set.
    assign w_addend  = r_q[0] ? r_mcand : '0;

    rca_n #(
        .WIDTH (WIDTH)
    ) u_rca (
        .a    (r_acc),
        .b    (w_addend),
        .cin  (1'b0),
        .s    (w_sum),
        .cout (w_cout)
    );

    // {acc,q} <= {cout,sum,q} >> 1 : the adder carry becomes the new acc MSB
    // and the sum LSB drops into the top of q as the multiplier shifts out.
    assign w_acc_next = {w_cout, w_sum[WIDTH-1:1]};
    assign w_q_next   = {w_sum[0], r_q[WIDTH-1:1]};

`ifdef MUL_ZERO_SKIP_EN
    logic w_zero_op;
    assign w_zero_op = (a == '0) || (b == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_mcand <= a;
                        r_q     <= b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
`ifdef MUL_ZERO_SKIP_EN
                        if (w_zero_op) begin
                            r_state   <= c_DONE;
                            r_product <= '0;
                        end else begin
                            r_state   <= c_BUSY;
                        end
`else
                        r_state <= c_BUSY;
`endif
                    end
                end
                c_BUSY: begin
                    r_acc <= w_acc_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    // The last iteration's shifted value is the full product.
                    if (r_cnt == c_CNT_LAST) begin
                        r_state   <= c_DONE;
                        r_product <= {w_acc_next, w_q_next};
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Directed self-checking bench for shift_add_multiplier
//               (WIDTH = 4). Inputs are driven and outputs sampled on the
//               falling clock edge.
// Config      : MUL_ZERO_SKIP_EN selects the expected zero-operand latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    localparam int W = 4;

`ifdef MUL_ZERO_SKIP_EN
    localparam int c_ZERO_EDGES = 0;
`else
    localparam int c_ZERO_EDGES = W;
`endif

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    shift_add_multiplier #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present an operand pair once in_ready is high and let it be accepted.
    // Returns at the falling edge right after the accept edge.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait_in_bound", int'(n < 50), 1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen; in_ready
    // must stay low the whole time.
    task automatic wait_done(input string tag, output int edges);
        int ready_seen;
        edges      = 0;
        ready_seen = 0;
        while (!out_valid && edges < 30) begin
            if (in_ready) ready_seen = 1;
            @(negedge clk);
            edges++;
        end
        chk({tag, "_in_ready_low_busy"}, ready_seen, 0);
    endtask

    // Complete the output handshake and confirm the return to IDLE.
    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_out_valid"}, int'(out_valid), 0);
        chk({tag, "_idle_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int edges;
        int seen;
        int n_acc;
        int n_out;
        int acc_cyc [2];
        int hs_cyc  [2];
        int prods   [2];
        int gap;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1 rst = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_product", int'(product), 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset two cycles into 9x7: operation abandoned.
        launch(4'd9, 4'd7);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midbusy_rst_in_ready", int'(in_ready), 1);
        chk("midbusy_rst_out_valid", int'(out_valid), 0);
        chk("midbusy_rst_product", int'(product), 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("midbusy_no_output", seen, 0);

        // Maximum operands 15x15
        launch(4'd15, 4'd15);
        wait_done("max", edges);
        chk("max_latency_edges", edges, W);
        chk("max_product", int'(product), 225);
        chk("max_in_ready_done", int'(in_ready), 0);
        finish_op("max");

        // Zero operand 0x9
        launch(4'd0, 4'd9);
        wait_done("zero", edges);
        chk("zero_latency_edges", edges, c_ZERO_EDGES);
        chk("zero_product", int'(product), 0);
        finish_op("zero");

        // Backpressure 13x11 with a pending 2x2 request
        launch(4'd13, 4'd11);
        wait_done("bp", edges);
        chk("bp_latency_edges", edges, W);
        in_valid = 1'b1;
        a        = 4'd2;
        b        = 4'd2;
        repeat (3) begin
            chk("bp_out_valid_held", int'(out_valid), 1);
            chk("bp_product_held", int'(product), 143);
            chk("bp_in_ready_low", int'(in_ready), 0);
            @(negedge clk);
        end
        chk("bp_product_after_hold", int'(product), 143);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_in_ready", int'(in_ready), 1);
        chk("bp_idle_out_valid", int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("bp2", edges);
        chk("bp2_latency_edges", edges, W);
        chk("bp2_product", int'(product), 4);
        finish_op("bp2");

        // Back-to-back 7x6 then 5x3 with out_ready tied high
        n_acc      = 0;
        n_out      = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        hs_cyc[0]  = 0;
        hs_cyc[1]  = 0;
        prods[0]   = 0;
        prods[1]   = 0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        a          = 4'd7;
        b          = 4'd6;
        for (int i = 0; i < 40 && n_out < 2; i++) begin
            if (in_valid && in_ready && n_acc < 2) begin
                acc_cyc[n_acc] = cyc + 1;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                prods[n_out]  = int'(product);
                hs_cyc[n_out] = cyc + 1;
                n_out++;
            end
            @(negedge clk);
            if (n_acc == 1) begin
                a = 4'd5;
                b = 4'd3;
            end else if (n_acc == 2) begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b_result_count", n_out, 2);
        chk("b2b_product0", prods[0], 42);
        chk("b2b_product1", prods[1], 15);
        chk("b2b_accept_gap", acc_cyc[1] - hs_cyc[0], 1);
        chk("b2b_first_handshake", hs_cyc[0] - acc_cyc[0], W + 1);

        // Exhaustive sweep with random request and consumer gaps
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                gap = int'($urandom_range(0, 2));
                repeat (gap) @(negedge clk);
                launch(W'(ia), W'(ib));
                wait_done("sweep", edges);
                if (ia == 0 || ib == 0) begin
                    chk("sweep_latency_edges", edges, c_ZERO_EDGES);
                end else begin
                    chk("sweep_latency_edges", edges, W);
                end
                chk("sweep_product", int'(product), ia * ib);
                seen = 0;
                while (seen < 20) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    seen++;
                    if (out_ready) break;
                end
                out_ready = 1'b0;
                chk("sweep_handshake_done", int'(out_valid), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

- Sequential unsigned WIDTH×WIDTH multiplier using a shift-and-add algorithm, with valid/ready handshakes on both sides.
- Each iteration issues one operand pair (accumulator, multiplicand) plus carry-in 0 to a WIDTH-bit ripple-carry adder. The block consumes the adder's sum and carry-out.
- Sits directly upstream of the adder. It is the first multi-cycle arithmetic stage in the datapath.

## Interface
Parameters:
- WIDTH, 4, operand width in bits (≥2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  unsigned a*b.

## Operation
State machine states:
- IDLE: in_ready=1, out_valid=0.
- BUSY: in_ready=0, out_valid=0.
- DONE: in_ready=0, out_valid=1.

Transitions:
- IDLE→BUSY on in_valid&&in_ready. Load mcand←a, q←b, acc←0, cnt←0.
- BUSY, each cycle:
  - {c,s} = acc + (q[0] ? mcand : 0), carry-in 0.
  - {acc,q} ← {c,s,q} >> 1.
  - cnt ← cnt+1.
- BUSY→DONE when cnt==WIDTH-1 at the edge. On that edge, product ← shifted {acc,q}.
- DONE→IDLE on out_valid&&out_ready.

Arithmetic and width rules:
- The adder is WIDTH bits wide; its carry-out becomes the MSB shifted into acc.
- Overflow is impossible: the product fits in 2*WIDTH bits.

Behaviour rules:
- in_valid is ignored outside IDLE. a and b are sampled only at the accept edge.
- product holds its last value until the next DONE entry; it is only meaningful while out_valid=1.
- Reset values: state IDLE, in_ready=1, out_valid=0, product=0, acc/q/mcand/cnt=0.
- Reset mid-BUSY or mid-DONE abandons the operation; no output is produced.
- No overlap between operations: a new operand pair is accepted only in IDLE.

## Timing
- If the accept happens at edge k, BUSY occupies edges k+1 … k+WIDTH and out_valid rises after edge k+WIDTH (latency WIDTH cycles).
- Product and out_valid are registered. in_ready and out_valid decode directly from state flops, with no combinational path from inputs.
- The DONE handshake at edge m puts the block back in IDLE after m. The next accept can happen at edge m+1 at the earliest.
- Peak throughput is one result per WIDTH+2 cycles.
- Backpressure: while out_ready=0 in DONE, out_valid stays 1 and product stays stable indefinitely.

## Configuration
- Macro MUL_ZERO_SKIP_EN.
- Defined: if a==0 or b==0 at the accept edge, the block goes IDLE→DONE directly. product←0 and out_valid rises after the accept edge (latency 1).
- Undefined: zero operands take the full WIDTH-cycle BUSY path. The result is the same; only the latency differs.

## Structure
- Package mul_pkg contains:
  - state enum typedef mul_state_t {IDLE, BUSY, DONE};
  - default width constant MUL_WIDTH=4;
  - counter width function/constant $clog2(WIDTH).
- One sub-module: rca_n, a combinational WIDTH-parameterised ripple-carry adder with ports s, cout, a, b, cin. It is instantiated once, with cin tied 0.
- The controller, shift registers and output register stay in shift_add_multiplier.

## Test plan
- Reset mid-BUSY: assert rst two cycles after accepting 9×7 → the cycle after reset in_ready=1, out_valid=0, product=0, and out_valid never rises for that operation.
- Maximum operands 15×15: product=225 (0xE1). out_valid rises exactly 4 cycles after the accept edge. in_ready=0 throughout BUSY/DONE.
- Zero operands 0×9:
  - product=0 in all cases.
  - With MUL_ZERO_SKIP_EN, out_valid is seen 1 cycle after accept.
  - Without it, out_valid is seen after 4 cycles.
- Backpressure 13×11: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with a=2, b=2 → product stays 143, out_valid stays 1, and 2×2 is not accepted until IDLE.
- Back-to-back with out_ready tied 1: 7×6 then 5×3 → products 42 then 15. The second accept occurs exactly 1 cycle after the first DONE handshake.
- Exhaustive: all 256 pairs with random in_valid/out_ready gaps → every product equals a*b, in order, with no drops or duplicates.
